// File: rtl/serial_digit_sender.sv
// Encodes a 4-digit value into 7-segment patterns and shifts them out as
// four 10-bit addressed frames, each followed by a latch clock, to the display controller.
module serial_digit_sender #(
    parameter int CLK_DIV    = 12,
    parameter int GAP_CYCLES = 48
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] value,
    input  logic [3:0]  dpMask,
    output logic        busy,
    output logic        done,
    output logic        serialClockOut,
    output logic        serialDataOut
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       LAST_SLOT = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [3:0]        slot_q, slot_d;
    logic [1:0]        frame_q, frame_d;
    logic [3:0][7:0]   seg_q, seg_d;
    logic              sck_q, sck_d;
    logic              sdo_q, sdo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    function automatic logic [7:0] encode(input logic [3:0] nib, input logic dp);
        logic [7:0] pat;
        case (nib)
            4'h0:    pat = 8'h3F;
            4'h1:    pat = 8'h21;
            4'h2:    pat = 8'h5B;
            4'h3:    pat = 8'h73;
            4'h4:    pat = 8'h65;
            4'h5:    pat = 8'h76;
            4'h6:    pat = 8'h7E;
            4'h7:    pat = 8'h23;
            4'h8:    pat = 8'h7F;
            4'h9:    pat = 8'h77;
            4'hA:    pat = 8'h40;
            default: pat = 8'h00;
        endcase
        return pat | {dp, 7'b0};
    endfunction

    // Slots 0..9 carry {addr, seg} MSB first; slot 10 is the latch clock with data low.
    function automatic logic frame_bit(input logic [1:0] idx, input logic [3:0] slot,
                                       input logic [3:0][7:0] segs);
        logic [9:0] word;
        logic       b;
        word = {idx, segs[idx]};
        b    = 1'b0;
        if (slot < 4'd10) begin
            b = word[4'd9 - slot];
        end
        return b;
    endfunction

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        slot_d  = slot_q;
        frame_d = frame_q;
        seg_d   = seg_q;
        sck_d   = sck_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                end
            end

            S_LOAD: begin
                for (int i = 0; i < 4; i++) begin
                    seg_d[i] = encode(value[4*i +: 4], dpMask[i]);
                end
                state_d = S_SHIFT;
                frame_d = 2'd0;
                slot_d  = 4'd0;
                div_d   = DIV_LOAD;
                sck_d   = 1'b0;
                sdo_d   = frame_bit(2'd0, 4'd0, seg_d);
            end

            S_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_LOAD;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // Data only moves together with the falling edge.
                        sck_d = 1'b0;
                        if (slot_q == LAST_SLOT) begin
                            sdo_d   = 1'b0;
                            gap_d   = GAP_LOAD;
                            state_d = S_GAP;
                        end else begin
                            slot_d = slot_q + 4'd1;
                            sdo_d  = frame_bit(frame_q, slot_q + 4'd1, seg_q);
                        end
                    end
                end
            end

            S_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (frame_q == 2'd3) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    frame_d = frame_q + 2'd1;
                    slot_d  = 4'd0;
                    div_d   = DIV_LOAD;
                    sdo_d   = frame_bit(frame_q + 2'd1, 4'd0, seg_q);
                    state_d = S_SHIFT;
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                sck_d   = 1'b0;
                sdo_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            slot_q  <= '0;
            frame_q <= '0;
            seg_q   <= '0;
            sck_q   <= 1'b0;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            slot_q  <= slot_d;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            sck_q   <= sck_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign serialClockOut = sck_q;
    assign serialDataOut  = sdo_q;

endmodule

// File: tb/tb_serial_digit_sender.sv
// Bench for serial_digit_sender: vector table through a receiver/timing model,
// plus hand-written sequences for start-while-busy, late value change and mid-frame reset.
module tb_serial_digit_sender;

    localparam int C = 12;
    localparam int G = 48;
    localparam int FRAME_CYC = 22 * C + G;
    localparam int DONE_AT   = 1 + 4 * FRAME_CYC;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] value;
    logic [3:0]  dpMask;
    logic        busy, done, serialClockOut, serialDataOut;

    int checks = 0;
    int errors = 0;

    serial_digit_sender #(.CLK_DIV(C), .GAP_CYCLES(G)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .value          (value),
        .dpMask         (dpMask),
        .busy           (busy),
        .done           (done),
        .serialClockOut (serialClockOut),
        .serialDataOut  (serialDataOut)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      mask;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs[6];

    // Receiver and timing model, sampled on the falling system clock edge.
    int         rises = 0, frames = 0, done_cnt = 0, viol = 0;
    int         run = 0, since = 0, bit_cnt = 0, frame_idx = 0;
    logic       prev_sck = 1'b0, prev_sdo = 1'b0;
    logic [9:0] shreg = '0;
    logic [7:0] digit[4];

    initial begin
        for (int i = 0; i < 4; i++) digit[i] = 8'h00;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_sck  = 1'b0;
                prev_sdo  = 1'b0;
                run       = 0;
                since     = 0;
                bit_cnt   = 0;
                frame_idx = 0;
                shreg     = '0;
            end else begin
                if (serialDataOut != prev_sdo) begin
                    since = 0;
                    if (serialClockOut) viol++;
                end else begin
                    since++;
                end
                if (serialClockOut != prev_sck) begin
                    if (prev_sck) begin
                        if (run != C) viol++;
                    end else begin
                        if (bit_cnt != 0 && run != C) viol++;
                        if (bit_cnt == 0 && run < C) viol++;
                        if (since < C) viol++;
                        rises++;
                        if (bit_cnt == 10) begin
                            if (serialDataOut) viol++;
                            if (int'(shreg[9:8]) != frame_idx) viol++;
                            digit[shreg[9:8]] = shreg[7:0];
                            frame_idx = (frame_idx + 1) % 4;
                            frames++;
                            bit_cnt = 0;
                        end else begin
                            shreg = {shreg[8:0], serialDataOut};
                            bit_cnt++;
                        end
                    end
                    run = 1;
                end else begin
                    run++;
                end
                if (done) done_cnt++;
                prev_sck = serialClockOut;
                prev_sdo = serialDataOut;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_txn(input logic [15:0] v, input logic [3:0] m, input logic [31:0] exp,
                           input int dup_at, input int chg_at, input string tag);
        int r0, f0, d0, v0, n, first_rise, done_at;
        r0 = rises; f0 = frames; d0 = done_cnt; v0 = viol;
        @(negedge clock);
        value = v; dpMask = m; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        chk({tag, " busy after start"}, int'(busy), 1);
        first_rise = -1;
        done_at    = -1;
        while (done_at < 0 && n < 3000) begin
            @(negedge clock);
            n++;
            if (n == dup_at) start = 1'b1;
            else if (n == dup_at + 1) start = 1'b0;
            if (n == chg_at) begin
                value  = ~v;
                dpMask = ~m;
            end
            if (first_rise < 0 && serialClockOut) first_rise = n;
            if (done) done_at = n;
        end
        chk({tag, " first sck rise cycle"}, first_rise, 1 + C);
        chk({tag, " done cycle"}, done_at, DONE_AT);
        @(negedge clock);
        chk({tag, " busy after done"}, int'(busy), 0);
        chk({tag, " done one cycle"}, int'(done), 0);
        repeat (3) @(negedge clock);
        chk({tag, " sck rises"}, rises - r0, 44);
        chk({tag, " frames"}, frames - f0, 4);
        chk({tag, " done pulses"}, done_cnt - d0, 1);
        chk({tag, " timing violations"}, viol - v0, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s digit%0d", tag, i), int'(digit[i]), int'(exp[8*i +: 8]));
        end
    endtask

    initial begin
        int bad, r0, n, target;

        //            value     mask    digit3 digit2 digit1 digit0
        vecs[0] = '{16'h1234, 4'b0000, {8'h21, 8'h5B, 8'h73, 8'h65}};
        vecs[1] = '{16'hA98F, 4'b0101, {8'h40, 8'hF7, 8'h7F, 8'h80}};
        vecs[2] = '{16'h0000, 4'b1111, {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
        vecs[3] = '{16'h5678, 4'b0010, {8'h76, 8'h7E, 8'hA3, 8'h7F}};
        vecs[4] = '{16'hEDCB, 4'b1000, {8'h80, 8'h00, 8'h00, 8'h00}};
        vecs[5] = '{16'h0A90, 4'b0110, {8'h3F, 8'hC0, 8'hF7, 8'h3F}};

        reset = 1'b1; start = 1'b0; value = '0; dpMask = '0;
        repeat (3) @(negedge clock);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset sck", int'(serialClockOut), 0);
        chk("reset sdo", int'(serialDataOut), 0);
        reset = 1'b0;

        r0  = rises;
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (busy || done || serialClockOut || serialDataOut) bad++;
        end
        chk("idle outputs nonzero", bad, 0);
        chk("idle sck rises", rises - r0, 0);

        for (int k = 0; k < 6; k++) begin
            run_txn(vecs[k].value, vecs[k].mask, vecs[k].exp, 0, 0, $sformatf("vec%0d", k));
        end

        run_txn(vecs[0].value, vecs[0].mask, vecs[0].exp, 10, 0, "start while busy");
        run_txn(vecs[1].value, vecs[1].mask, vecs[1].exp, 0, 1 + FRAME_CYC + 22 * C + 5,
                "value change in gap");

        // Reset while SCK is high in slot 5 of frame 2.
        r0 = rises;
        @(negedge clock);
        value = vecs[3].value; dpMask = vecs[3].mask; start = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        target = 1 + 2 * FRAME_CYC + 11 * C + 2;
        for (n = 1; n <= target; n++) @(negedge clock);
        chk("abort sck high before reset", int'(serialClockOut), 1);
        reset = 1'b1;
        #1;
        chk("abort sck async", int'(serialClockOut), 0);
        chk("abort sdo async", int'(serialDataOut), 0);
        chk("abort busy async", int'(busy), 0);
        chk("abort rises before reset", rises - r0, 28);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("abort idle after reset", int'(busy), 0);
        run_txn(vecs[5].value, vecs[5].mask, vecs[5].exp, 0, 0, "after abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
